apb_req_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer in front of the APB master's user-side port.

---
 rtl/apb_req_arbiter.sv | 171 +++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master user port between NUM_REQ requesters.
// Sequences each accepted request through XFER/HOLD/RESP and returns read data and slave error.
module apb_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int XFER_CYCLES = 2,
    parameter int ERRCNT_W    = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*9-1:0]  req_addr,
    input  logic [NUM_REQ*8-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_err,
    output logic                  transfer,
    output logic                  READ_WRITE,
    output logic [8:0]            apb_write_paddr,
    output logic [7:0]            apb_write_data,
    output logic [8:0]            apb_read_paddr,
    input  logic                  PSLVERR,
    input  logic [7:0]            apb_read_data_out,
    output logic [ERRCNT_W-1:0]   err_count,
    output logic                  busy
);

    // state | meaning
    // IDLE  | no transaction, master-side outputs 0, accepting requests
    // XFER  | transfer high, XFER_CYCLES cycles
    // HOLD  | transfer low, buses held, read data/PSLVERR captured on exit
    // RESP  | rsp_valid to owner, may accept the next request
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_HOLD = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(XFER_CYCLES + 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XFER_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic                wr_q, wr_d;
    logic [8:0]          addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic                hs;
    logic                drive;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        logic [PTR_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign hs = grant_found && (state_q == ST_IDLE || state_q == ST_RESP);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = ST_XFER;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_XFER: begin
                if (cnt_q == '0) state_d = ST_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_HOLD: begin
                state_d = ST_RESP;
                rdata_d = wr_q ? 8'h00 : apb_read_data_out;
                err_d   = PSLVERR;
            end
            ST_RESP: begin
                if (err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
                if (hs) begin
                    state_d = ST_XFER;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (hs) begin
            rr_ptr_d = grant_idx;
            owner_d  = grant_idx;
            wr_d     = req_write[grant_idx];
            addr_d   = req_addr[9*grant_idx +: 9];
            wdata_d  = req_wdata[8*grant_idx +: 8];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rr_ptr_q  <= PTR_INIT;
            owner_q   <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Master-side buses follow the latched request from XFER through RESP.
    assign drive = (state_q != ST_IDLE);

    always_comb begin
        req_ready       = hs ? (NUM_REQ'(1) << grant_idx) : '0;
        rsp_valid       = (state_q == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
        transfer        = (state_q == ST_XFER);
        busy            = (state_q == ST_XFER) || (state_q == ST_HOLD);
        READ_WRITE      = drive && !wr_q;
        apb_write_paddr = (drive && wr_q)  ? addr_q  : 9'h000;
        apb_write_data  = (drive && wr_q)  ? wdata_q : 8'h00;
        apb_read_paddr  = (drive && !wr_q) ? addr_q  : 9'h000;
        rsp_rdata       = rdata_q;
        rsp_err         = err_q;
        err_count       = err_cnt_q;
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized and directed bench for apb_req_arbiter against a transaction-timeline model.
// Each accepted request is tracked by its age in cycles since the handshake.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int XC = 2;
    localparam int EW = 8;

    logic            PCLK;
    logic            PRESETn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*9-1:0]  req_addr;
    logic [N*8-1:0]  req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [7:0]      rsp_rdata;
    logic            rsp_err;
    logic            transfer;
    logic            READ_WRITE;
    logic [8:0]      apb_write_paddr;
    logic [7:0]      apb_write_data;
    logic [8:0]      apb_read_paddr;
    logic            PSLVERR;
    logic [7:0]      apb_read_data_out;
    logic [EW-1:0]   err_count;
    logic            busy;

    apb_req_arbiter #(.NUM_REQ(N), .XFER_CYCLES(XC), .ERRCNT_W(EW)) dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .req_valid         (req_valid),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .PSLVERR           (PSLVERR),
        .apb_read_data_out (apb_read_data_out),
        .err_count         (err_count),
        .busy              (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int vec_cnt = 0;
    int miscmp  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction aged m_k cycles since its handshake.
    bit m_active;
    int m_k;
    int m_owner;
    bit m_wr;
    int m_addr;
    int m_wdata;
    int m_rr;
    int m_rdata;
    bit m_err;
    int m_errcnt;
    int cyc;
    int grant_log[$];
    int grant_time[$];

    task automatic m_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_rr     = N - 1;
        m_rdata  = 0;
        m_err    = 1'b0;
        m_errcnt = 0;
    endtask

    function automatic int winner();
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (m_rr + i) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step();
        int w;
        bit free;
        int e_ready;
        bit drv;
        @(negedge PCLK);
        w       = winner();
        free    = !m_active || (m_k == XC + 2);
        e_ready = (free && w >= 0) ? (1 << w) : 0;
        drv     = m_active;
        check("req_ready",  32'(req_ready), 32'(e_ready));
        check("rsp_valid",  32'(rsp_valid), (m_active && m_k == XC + 2) ? 32'(1 << m_owner) : 32'd0);
        check("transfer",   32'(transfer),  32'(m_active && m_k >= 1 && m_k <= XC));
        check("busy",       32'(busy),      32'(m_active && m_k <= XC + 1));
        check("read_write", 32'(READ_WRITE), 32'(drv && !m_wr));
        check("wr_paddr",   32'(apb_write_paddr), (drv && m_wr)  ? 32'(m_addr)  : 32'd0);
        check("wr_data",    32'(apb_write_data),  (drv && m_wr)  ? 32'(m_wdata) : 32'd0);
        check("rd_paddr",   32'(apb_read_paddr),  (drv && !m_wr) ? 32'(m_addr)  : 32'd0);
        check("rsp_rdata",  32'(rsp_rdata), 32'(m_rdata));
        check("rsp_err",    32'(rsp_err),   32'(m_err));
        check("err_count",  32'(err_count), 32'(m_errcnt));

        if (m_active && m_k == XC + 1) begin
            m_rdata = m_wr ? 0 : int'(apb_read_data_out);
            m_err   = PSLVERR;
        end
        if (m_active && m_k == XC + 2 && m_err && m_errcnt < (1 << EW) - 1) m_errcnt++;
        if (free && w >= 0) begin
            m_active = 1'b1;
            m_k      = 1;
            m_owner  = w;
            m_rr     = w;
            m_wr     = req_write[w];
            m_addr   = int'(req_addr[9*w +: 9]);
            m_wdata  = int'(req_wdata[8*w +: 8]);
            grant_log.push_back(w);
            grant_time.push_back(cyc);
        end else if (m_active) begin
            m_k++;
            if (m_k > XC + 2) m_active = 1'b0;
        end
        cyc++;
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(int i, bit v, bit wr, logic [8:0] a, logic [7:0] d);
        req_valid[i]         = v;
        req_write[i]         = wr;
        req_addr[9*i +: 9]   = a;
        req_wdata[8*i +: 8]  = d;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_active && guard < 20) begin
            step();
            guard++;
        end
        check("idle_timeout", 32'(m_active), 32'd0);
    endtask

    initial begin
        int g0;
        int guard;
        PRESETn           = 1'b0;
        req_valid         = '0;
        req_write         = '0;
        req_addr          = '0;
        req_wdata         = '0;
        PSLVERR           = 1'b0;
        apb_read_data_out = 8'h00;
        cyc               = 0;
        m_reset();
        m_owner = 0;
        m_wr    = 1'b0;
        m_addr  = 0;
        m_wdata = 0;
        repeat (2) step();
        PRESETn = 1'b1;
        step();

        // Single write from req0
        set_req(0, 1'b1, 1'b1, 9'h012, 8'hA5);
        g0 = grant_log.size();
        step();
        set_req(0, 1'b0, 1'b0, 9'h000, 8'h00);
        check("t1_grant", 32'(grant_log[g0]), 32'd0);
        wait_idle();
        check("t1_err", 32'(rsp_err), 32'd0);

        // Single read from req1
        apb_read_data_out = 8'h3C;
        set_req(1, 1'b1, 1'b0, 9'h1F0, 8'h77);
        step();
        set_req(1, 1'b0, 1'b0, 9'h000, 8'h00);
        wait_idle();
        check("t2_rdata", 32'(rsp_rdata), 32'h3C);
        step();

        // Reset in the middle of XFER, then all requesters hold valid
        set_req(2, 1'b1, 1'b1, 9'h0AA, 8'h55);
        step();
        check("t5_in_xfer", 32'(transfer), 32'd1);
        PRESETn   = 1'b0;
        req_valid = '0;
        #2;
        check("t5_rst_transfer", 32'(transfer), 32'd0);
        check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_paddr", 32'(apb_write_paddr), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        m_reset();
        repeat (2) step();
        PRESETn = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, i[0], 9'(9'h100 + i), 8'(8'h10 * i));
        g0 = grant_log.size();
        repeat (21) step();
        check("t3_first_grant", 32'(grant_log[g0]), 32'd0);
        for (int j = 1; j < 5; j++) begin
            check("t3_rr_order", 32'(grant_log[g0+j]), 32'((grant_log[g0+j-1] + 1) % N));
            check("t3_period", 32'(grant_time[g0+j] - grant_time[g0+j-1]), 32'(XC + 2));
        end
        req_valid = '0;
        wait_idle();

        // req2 drops valid in the cycle req0 is accepted
        set_req(3, 1'b1, 1'b0, 9'h033, 8'h00);
        step();
        set_req(3, 1'b0, 1'b0, 9'h000, 8'h00);
        set_req(2, 1'b1, 1'b1, 9'h022, 8'h22);
        guard = 0;
        while (!(m_active && m_k == XC + 2) && guard < 20) begin
            step();
            guard++;
        end
        check("t6_reach_resp", 32'(m_active && m_k == XC + 2), 32'd1);
        set_req(2, 1'b0, 1'b1, 9'h022, 8'h22);
        set_req(0, 1'b1, 1'b1, 9'h000, 8'h0F);
        g0 = grant_log.size();
        step();
        set_req(0, 1'b0, 1'b0, 9'h000, 8'h00);
        wait_idle();
        check("t6_grants", 32'(grant_log.size() - g0), 32'd1);
        check("t6_winner", 32'(grant_log[g0]), 32'd0);

        // Three erroring transactions
        PSLVERR = 1'b1;
        set_req(1, 1'b1, 1'b0, 9'h011, 8'h00);
        g0 = grant_log.size();
        guard = 0;
        while (grant_log.size() - g0 < 3 && guard < 40) begin
            step();
            guard++;
        end
        set_req(1, 1'b0, 1'b0, 9'h000, 8'h00);
        wait_idle();
        PSLVERR = 1'b0;
        step();
        check("t4_err_count", 32'(err_count), 32'd3);
        check("t4_rsp_err", 32'(rsp_err), 32'd1);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
                        9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
            apb_read_data_out = 8'($urandom_range(0, 255));
            PSLVERR           = ($urandom_range(0, 3) == 0);
            step();
        end

        // Saturate the error counter
        PSLVERR = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 9'(i), 8'h00);
        repeat (1100) begin
            apb_read_data_out = 8'($urandom_range(0, 255));
            step();
        end
        req_valid = '0;
        wait_idle();
        step();
        check("sat_err_count", 32'(err_count), 32'((1 << EW) - 1));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
